// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: 32-bit-word data memory with a request/response handshake.
// It supports byte, halfword and word accesses with little-endian lanes and
// sign or zero extension on loads. Misaligned, illegal-size and out-of-range
// requests are rejected with Fault. After every reset the memory zero-fills
// itself one word per cycle before it accepts requests.
module data_memory_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  Write,
    input  logic [1:0]            Size,
    input  logic                  Signed,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    output logic                  Ready,
    output logic                  RespValid,
    output logic [31:0]           ReadData,
    output logic                  Fault
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IDX_W:0]   DEPTH_L    = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(DEPTH - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] clear_cnt;
    logic             clear_en;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic [CNT_W-1:0] mem_idx;
    logic [1:0]       offset;
    logic             in_range;
    logic             accept;
    logic             req_fault;
    logic             store_en;
    logic [3:0]       byte_en;
    logic [31:0]      store_word;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shifted;
    logic [31:0]      load_val;

    assign word_idx = Address[ADDR_WIDTH-1:2];
    assign mem_idx  = word_idx[CNT_W-1:0];
    assign offset   = Address[1:0];
    assign in_range = ({1'b0, word_idx} < DEPTH_L);
    assign accept   = Req && Ready;
    assign store_en = accept && Write && !req_fault;

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge, independent of block order.
        if (Reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave CLEAR once the last word has been zeroed.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_CLEAR: if (clear_cnt == CLEAR_LAST) state_next = ST_IDLE;
            ST_IDLE:  state_next = ST_IDLE;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // State outputs: requests are taken only in IDLE, words are zeroed in CLEAR.
    always_comb begin
        Ready    = 1'b0;
        clear_en = 1'b0;
        unique case (state)
            ST_CLEAR: clear_en = 1'b1;
            ST_IDLE:  Ready    = 1'b1;
            default:  clear_en = 1'b1;
        endcase
    end

    // Clear counter: points at the next word to zero while in CLEAR.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clear_cnt <= '0;
        end else if (clear_en) begin
            clear_cnt <= (clear_cnt == CLEAR_LAST) ? '0 : clear_cnt + CNT_W'(1);
        end
    end

    // Fault check: illegal size, misalignment for the size, or word past DEPTH.
    always_comb begin
        req_fault = 1'b0;
        unique case (Size)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = offset[0];
            SZ_WORD: req_fault = (offset != 2'b00);
            default: req_fault = 1'b1;
        endcase
        if (!in_range) begin
            req_fault = 1'b1;
        end
    end

    // Store lanes: replicate the right-aligned data over every lane, then
    // enable only the lane(s) the address selects.
    always_comb begin
        byte_en    = 4'b0000;
        store_word = '0;
        unique case (Size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << offset;
                store_word = {4{WriteData[7:0]}};
            end
            SZ_HALF: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_word = {2{WriteData[15:0]}};
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                store_word = WriteData;
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = '0;
            end
        endcase
    end

    // Load extraction: shift the addressed lane(s) down to bit 0 and extend.
    always_comb begin
        rd_word    = in_range ? mem[mem_idx] : '0;
        rd_shifted = rd_word >> {offset, 3'b000};
        load_val   = '0;
        unique case (Size)
            SZ_BYTE: load_val = {{24{Signed & rd_shifted[7]}}, rd_shifted[7:0]};
            SZ_HALF: load_val = {{16{Signed & rd_shifted[15]}}, rd_shifted[15:0]};
            SZ_WORD: load_val = rd_word;
            default: load_val = '0;
        endcase
    end

    // Memory array: zeroed by the clear sweep, byte-lane writes on stores.
    // Reset blocks any write that coincides with it.
    always_ff @(posedge Clock) begin
        // NOTE: the array has no reset branch; clearing it word by word keeps it
        // a plain RAM instead of DEPTH*32 resettable flops.
        if (!Reset) begin
            if (clear_en) begin
                mem[clear_cnt] <= '0;
            end else if (store_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (byte_en[k]) begin
                        mem[mem_idx][8*k +: 8] <= store_word[8*k +: 8];
                    end
                end
            end
        end
    end

    // Response register: one-cycle pulse per accepted request, data and fault
    // forced to 0 whenever there is no valid load result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            RespValid <= 1'b0;
            Fault     <= 1'b0;
            ReadData  <= '0;
        end else begin
            RespValid <= accept;
            Fault     <= accept && req_fault;
            ReadData  <= (accept && !Write && !req_fault) ? load_val : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed steps from the test plan
// followed by randomized traffic, all checked against a byte-array model.
module tb_data_memory_ctrl;

    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 64;

    logic                  Clock;
    logic                  Reset;
    logic                  Req;
    logic                  Write;
    logic [1:0]            Size;
    logic                  Signed;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           WriteData;
    logic                  Ready;
    logic                  RespValid;
    logic [31:0]           ReadData;
    logic                  Fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory as a flat little-endian byte array.
    logic [7:0] ref_mem [DEPTH*4];

    data_memory_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req      (Req),
        .Write    (Write),
        .Size     (Size),
        .Signed   (Signed),
        .Address  (Address),
        .WriteData(WriteData),
        .Ready    (Ready),
        .RespValid(RespValid),
        .ReadData (ReadData),
        .Fault    (Fault)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic bit model_fault(input logic [1:0] sz, input int addr);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
        if ((addr / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg, input int addr);
        int          nbytes;
        logic [31:0] v;
        nbytes = 1 << sz;
        v      = 32'd0;
        for (int i = 0; i < nbytes; i++) begin
            v = v | (32'(ref_mem[addr + i]) << (8 * i));
        end
        if (nbytes < 4 && sg && v[8*nbytes-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * nbytes));
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input int addr, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) begin
            ref_mem[addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    endtask

    // Issue one request for one cycle (Req is left high for back-to-back use)
    // and check the response against the model.
    task automatic do_req(input string tag, input bit wr, input logic [1:0] sz,
                          input bit sg, input int addr, input logic [31:0] wd);
        bit          f;
        logic [31:0] exp_data;
        f        = model_fault(sz, addr);
        exp_data = (f || wr) ? 32'd0 : model_load(sz, sg, addr);
        if (!f && wr) model_store(sz, addr, wd);
        Req       = 1'b1;
        Write     = wr;
        Size      = sz;
        Signed    = sg;
        Address   = ADDR_WIDTH'(addr);
        WriteData = wd;
        tick();
        check({tag, "_valid"}, 32'(RespValid), 32'd1);
        check({tag, "_fault"}, 32'(Fault), 32'(f));
        check({tag, "_data"}, ReadData, exp_data);
    endtask

    task automatic idle(input string tag);
        Req = 1'b0;
        tick();
        check({tag, "_valid"}, 32'(RespValid), 32'd0);
        check({tag, "_data"}, ReadData, 32'd0);
        check({tag, "_fault"}, 32'(Fault), 32'd0);
    endtask

    // Count cycles from reset release until Ready rises; responses must stay low.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (Ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            check({tag, "_no_resp"}, 32'(RespValid), 32'd0);
        end
        check({tag, "_len"}, 32'(n), 32'd64);
        model_clear();
    endtask

    initial begin
        Reset     = 1'b1;
        Req       = 1'b0;
        Write     = 1'b0;
        Size      = 2'b10;
        Signed    = 1'b0;
        Address   = '0;
        WriteData = '0;

        // Reset for two cycles, then the clear sweep with Req held high.
        tick();
        tick();
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_valid", 32'(RespValid), 32'd0);
        check("rst_data", ReadData, 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        Req   = 1'b1;
        Reset = 1'b0;
        wait_clear("clear1");
        Req = 1'b0;

        // Every word reads back as zero.
        for (int i = 0; i < DEPTH; i++) do_req("zero_rd", 1'b0, 2'd2, 1'b0, i * 4, 32'd0);
        idle("idle0");

        // Word and byte stores, then loads of each width.
        do_req("st_w10", 1'b1, 2'd2, 1'b0, 'h10, 32'hDEAD_BEEF);
        do_req("st_b12", 1'b1, 2'd0, 1'b0, 'h12, 32'h0000_0080);
        do_req("ld_w10", 1'b0, 2'd2, 1'b0, 'h10, 32'd0);
        check("ld_w10_lit", ReadData, 32'hDE80_BEEF);
        do_req("ld_bs12", 1'b0, 2'd0, 1'b1, 'h12, 32'd0);
        check("ld_bs12_lit", ReadData, 32'hFFFF_FF80);
        do_req("ld_bu12", 1'b0, 2'd0, 1'b0, 'h12, 32'd0);
        check("ld_bu12_lit", ReadData, 32'h0000_0080);
        do_req("ld_hs10", 1'b0, 2'd1, 1'b1, 'h10, 32'd0);
        check("ld_hs10_lit", ReadData, 32'hFFFF_BEEF);
        do_req("ld_hu12", 1'b0, 2'd1, 1'b0, 'h12, 32'd0);
        check("ld_hu12_lit", ReadData, 32'h0000_DE80);
        idle("idle1");

        // Faulting requests leave word 0x04 untouched.
        do_req("st_w04", 1'b1, 2'd2, 1'b0, 'h04, 32'h0BAD_F00D);
        do_req("flt_h11", 1'b0, 2'd1, 1'b0, 'h11, 32'd0);
        check("flt_h11_lit", 32'(Fault), 32'd1);
        do_req("flt_w06", 1'b1, 2'd2, 1'b0, 'h06, 32'h1234_5678);
        check("flt_w06_lit", 32'(Fault), 32'd1);
        do_req("flt_sz3", 1'b0, 2'd3, 1'b0, 'h00, 32'hFFFF_FFFF);
        check("flt_sz3_lit", 32'(Fault), 32'd1);
        do_req("flt_rng", 1'b0, 2'd2, 1'b0, 'h100, 32'd0);
        check("flt_rng_lit", 32'(Fault), 32'd1);
        do_req("ld_w04", 1'b0, 2'd2, 1'b0, 'h04, 32'd0);
        check("ld_w04_lit", ReadData, 32'h0BAD_F00D);
        idle("idle2");

        // Back-to-back store then load of the same word.
        do_req("b2b_st", 1'b1, 2'd2, 1'b0, 'h20, 32'hA5A5_A5A5);
        do_req("b2b_ld", 1'b0, 2'd2, 1'b0, 'h20, 32'd0);
        check("b2b_ld_lit", ReadData, 32'hA5A5_A5A5);
        idle("idle3");

        // Reset reasserted at clear step 30 restarts a full clear.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("mid_ready", 32'(Ready), 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        wait_clear("clear2");

        // Reset on the same edge as a store: no response, no write.
        Req       = 1'b1;
        Write     = 1'b1;
        Size      = 2'd2;
        Address   = ADDR_WIDTH'('h08);
        WriteData = 32'h1111_1111;
        Reset     = 1'b1;
        tick();
        check("rst_st_valid", 32'(RespValid), 32'd0);
        Req   = 1'b0;
        Reset = 1'b0;
        wait_clear("clear3");
        do_req("rst_st_rd", 1'b0, 2'd2, 1'b0, 'h08, 32'd0);
        check("rst_st_rd_lit", ReadData, 32'd0);
        idle("idle4");

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle("rnd_idle");
            end else begin
                bit          wr;
                bit          sg;
                logic [1:0]  sz;
                int          addr;
                wr = 1'($urandom_range(0, 1));
                sg = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) addr = int'($urandom_range(0, 1023));
                else addr = int'($urandom_range(0, DEPTH*4 - 1));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) addr = addr & ~1;
                    if (sz == 2'd2) addr = addr & ~3;
                end
                do_req("rnd", wr, sz, sg, addr, $urandom);
            end
        end
        idle("idle_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data memory for the single-cycle/pipelined datapath. It adds a request/response handshake, byte, halfword and word accesses with little-endian lane selection, and sign or zero extension on loads. It reports alignment and range faults and zero-fills itself after reset. It sits between the datapath's memory stage and the register-file writeback mux, and all activity is on the rising edge of one clock.

## Interface
- ADDR_WIDTH, default 8: byte-address width; word index = Address[ADDR_WIDTH-1:2].
- DEPTH, default 64: number of 32-bit words; legal range is 1 to 2^(ADDR_WIDTH-2).
- Clock  in  1  sole clock; everything is on posedge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  request strobe; accepted on a rising edge when Req && Ready.
- Write  in  1  1 = store, 0 = load.
- Size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- Signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- Address  in  ADDR_WIDTH  byte address.
- WriteData  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- Ready  out  1  able to accept a request.
- RespValid  out  1  one-cycle pulse per accepted request.
- ReadData  out  32  load result, valid only while RespValid=1.
- Fault  out  1  qualifies RespValid; 1 = request rejected.

## Operation
- The state machine has two states: CLEAR and IDLE.
- **Reset (Reset=1 at an edge):**
  - state goes to CLEAR; clear counter goes to 0.
  - Ready=0, RespValid=0, ReadData=0, Fault=0.
  - Any in-flight response is discarded.
- **CLEAR:**
  - At each edge with Reset=0, write 0 to word[counter] and increment the counter.
  - After the edge that writes word DEPTH-1, go to IDLE with Ready=1.
  - Req is ignored while Ready=0.
- **IDLE:**
  - Ready stays 1; one request can be accepted every cycle.
  - With no accepted request, RespValid=0 on the next cycle.
- **Fault check (at acceptance):**
  - Size=11 faults.
  - Size=01 with Address[0]≠0 faults.
  - Size=10 with Address[1:0]≠0 faults.
  - Word index ≥ DEPTH faults.
  - A faulting request leaves memory unchanged. Its response has Fault=1 and ReadData=0.
- **Lane mapping:** byte k of a word is bits [8k+7:8k]; the byte offset is Address[1:0].
- **Store:**
  - Only the addressed lane(s) are written, at the accepting edge.
  - Byte: WriteData[7:0] goes to lane Address[1:0].
  - Half: WriteData[15:0] goes to lanes Address[1]*2 and Address[1]*2+1.
  - Word: all four lanes are written.
  - Other lanes are preserved.
  - Response: RespValid=1, Fault=0, ReadData=0.
- **Load:**
  - The addressed lane(s) are extracted and shifted to bit 0.
  - Bits above the access size are filled per Signed (sign bit or 0).
  - Word loads ignore Signed.
  - Response: RespValid=1, Fault=0, ReadData = the extended value.
- **Store then load:**
  - A store accepted at edge N followed by a load of the same word accepted at edge N+1 returns the stored data.
  - The update is visible at the next edge, so no bypass is needed.

## Timing
- Request latency is exactly one cycle: a request accepted at edge N gives RespValid=1 in the cycle after edge N, deasserting after edge N+1 unless another request is accepted at N+1.
- Throughput is 1 request/cycle, and responses come back in order.
- ReadData and Fault are 0 whenever RespValid=0.
- Clear duration: with Reset deasserted before edge E, the edges E … E+DEPTH-1 perform the clear, and Ready=1 after edge E+DEPTH-1.
- If Reset is reasserted during CLEAR, the clear restarts from word 0.
- If Reset coincides with an accepted request, Reset wins: there is no write and no response.

## Test plan
- **Reset/clear:** assert Reset for 2 cycles, then release -> Ready=0 for exactly DEPTH=64 cycles and then 1. A word load of every address returns 0x00000000 with Fault=0.
- **Word and byte stores:**
  - Store word 0xDEADBEEF to 0x10, then store byte 0x80 to 0x12.
  - Word load of 0x10 -> 0xDE80BEEF.
  - Signed byte load of 0x12 -> 0xFFFFFF80.
  - Unsigned byte load of 0x12 -> 0x00000080.
- **Halfword load:** signed half load of 0x10 after the above -> 0xFFFFBEEF; unsigned half load of 0x12 -> 0x0000DE80.
- **Faults:**
  - Each of the following -> RespValid=1, Fault=1, ReadData=0, and a later word load of 0x04 is unchanged:
    - half load at 0x11;
    - word store of 0x12345678 at 0x06;
    - Size=11 at 0x00;
    - word load at 0x100 with ADDR_WIDTH=10, DEPTH=64.
- **Back-to-back traffic:**
  - Store 0xA5A5A5A5 to 0x20 at edge N, then word load 0x20 at N+1 with Req held high.
  - Expect RespValid high for cycles N+1 and N+2, with the second response returning 0xA5A5A5A5.
- **Reset mid-operation:**
  - Assert Reset at clear step 30 -> Ready stays 0 for a further full 64-cycle clear.
  - Assert Reset on the same edge as a word store of 0x11111111 to 0x08 -> no response, and the word at 0x08 reads back 0 after the clear completes.
